// File: rtl/array_ops_pkg.sv
// rtl/array_ops_pkg.sv - shared flat-array layout helpers and packer state type
package array_ops_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } pack_state_t;

  // Bit offset of element (row, col) in a flat array; columns are the slow axis.
  function automatic int unsigned flat_offset(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned rows,
                                              input int unsigned bit_width);
    return (col * rows + row) * bit_width;
  endfunction

endpackage

// File: rtl/array_index_counter.sv
// rtl/array_index_counter.sv - row-fastest row/col walker over a ROWS x COLS array
module array_index_counter #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2((ROWS > 1) ? ROWS : 2),
  parameter int CW   = $clog2((COLS > 1) ? COLS : 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic row_wrap;
  logic col_wrap;

  assign row_wrap = (row == RW'(ROWS - 1));
  assign col_wrap = (col == CW'(COLS - 1));
  assign last     = row_wrap & col_wrap;

  // Row advances every step; column advances when the row wraps. Clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (row_wrap) begin
        row <= '0;
        col <= col_wrap ? '0 : col + CW'(1);
      end else begin
        row <= row + RW'(1);
      end
    end
  end

endmodule

// File: rtl/stream_to_1d_array_packer.sv
// rtl/stream_to_1d_array_packer.sv - element stream to flat ROWS x COLS frame packer
module stream_to_1d_array_packer
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int ROWS      = 8,
  parameter int COLS      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [BIT_WIDTH-1:0]                 in_data,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [$clog2((ROWS > 1) ? ROWS : 2)-1:0] cur_row,
  output logic [$clog2((COLS > 1) ? COLS : 2)-1:0] cur_col,
  output logic [ROWS*COLS*BIT_WIDTH-1:0]       out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 err_len
);

  localparam int N  = ROWS * COLS;
  localparam int FW = N * BIT_WIDTH;
  localparam int RW = $clog2((ROWS > 1) ? ROWS : 2);
  localparam int CW = $clog2((COLS > 1) ? COLS : 2);

  pack_state_t state_q, state_d;
  logic [FW-1:0] asm_q, asm_d, asm_next, out_src;
  logic          accept, complete, cnt_last, slot_free, load_out;
  logic          out_valid_d, len_mismatch;
  int unsigned   flat_idx;

  array_index_counter #(
    .ROWS(ROWS),
    .COLS(COLS),
    .RW  (RW),
    .CW  (CW)
  ) u_idx (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (accept),
    .clr  (complete),
    .row  (cur_row),
    .col  (cur_col),
    .last (cnt_last)
  );

  assign in_ready     = rst_n && (state_q == FILL);
  assign accept       = in_valid & in_ready;
  assign complete     = accept & (cnt_last | in_last);
  assign len_mismatch = accept & (cnt_last ^ in_last);
  assign slot_free    = ~out_valid | out_ready;
  assign flat_idx     = flat_offset(32'(cur_row), 32'(cur_col), 32'(ROWS), 32'd1);

  // Assembly register with the element being accepted this cycle merged in.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < N; k++) begin
      if (accept && (flat_idx == 32'(k))) begin
        asm_next[k*BIT_WIDTH +: BIT_WIDTH] = in_data;
      end
    end
  end

  // Frame hand-off: load the output slot when free, otherwise park the frame in FULL.
  always_comb begin
    state_d  = state_q;
    asm_d    = asm_next;
    load_out = 1'b0;
    out_src  = asm_next;
    case (state_q)
      FILL: begin
        if (complete) begin
          if (slot_free) begin
            load_out = 1'b1;
            asm_d    = '0;
          end else begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        out_src = asm_q;
        if (slot_free) begin
          load_out = 1'b1;
          asm_d    = '0;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    out_valid_d = load_out | (out_valid & ~out_ready);
  end

  // State, assembly and output registers; reset drops partial and held frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      asm_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      state_q   <= state_d;
      asm_q     <= asm_d;
      out_valid <= out_valid_d;
      err_len   <= len_mismatch;
      if (load_out) begin
        out_data <= out_src;
      end
    end
  end

endmodule

// File: tb/tb_stream_to_1d_array_packer.sv
// tb/tb_stream_to_1d_array_packer.sv - directed and randomized checks of the frame packer
module tb_stream_to_1d_array_packer;

  logic clk;
  logic rst_n;

  logic [3:0]  a_in_data;
  logic        a_in_valid, a_in_last, a_in_ready;
  logic [0:0]  a_cur_row;
  logic [1:0]  a_cur_col;
  logic [23:0] a_out_data;
  logic        a_out_valid, a_out_ready, a_err_len;

  logic [3:0]   b_in_data;
  logic         b_in_valid, b_in_last, b_in_ready;
  logic [2:0]   b_cur_row, b_cur_col;
  logic [255:0] b_out_data;
  logic         b_out_valid, b_out_ready, b_err_len;

  int errors = 0;
  int checks = 0;

  stream_to_1d_array_packer #(.BIT_WIDTH(4), .ROWS(2), .COLS(3)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (a_in_data),
    .in_valid (a_in_valid),
    .in_last  (a_in_last),
    .in_ready (a_in_ready),
    .cur_row  (a_cur_row),
    .cur_col  (a_cur_col),
    .out_data (a_out_data),
    .out_valid(a_out_valid),
    .out_ready(a_out_ready),
    .err_len  (a_err_len)
  );

  stream_to_1d_array_packer #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (b_in_data),
    .in_valid (b_in_valid),
    .in_last  (b_in_last),
    .in_ready (b_in_ready),
    .cur_row  (b_cur_row),
    .cur_col  (b_cur_col),
    .out_data (b_out_data),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .err_len  (b_err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_send(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    a_in_data  = d;
    a_in_last  = last;
    a_in_valid = 1'b1;
    while (!a_in_ready && n < 50) begin
      step();
      n++;
    end
    if (!a_in_ready) chk("a_send_timeout", 256'(a_in_ready), 256'd1);
    step();
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic a_send_frame(input logic [3:0] base, input logic last_on_end);
    for (int i = 0; i < 6; i++) begin
      a_send(base + 4'(i), (i == 5) ? last_on_end : 1'b0);
    end
  endtask

  initial begin
    logic [255:0] q[$];
    logic [255:0] asm_m;
    logic [255:0] exp_frame;
    int consumed, cyc, k;

    rst_n       = 1'b0;
    a_in_data   = '0; a_in_valid = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b0;
    b_in_data   = '0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0;
    step();
    step();
    chk("rst_in_ready",  256'(a_in_ready),  256'd0);
    chk("rst_out_valid", 256'(a_out_valid), 256'd0);
    chk("rst_out_data",  256'(a_out_data),  256'd0);
    chk("rst_cur_row",   256'(a_cur_row),   256'd0);
    chk("rst_cur_col",   256'(a_cur_col),   256'd0);
    chk("rst_err_len",   256'(a_err_len),   256'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 256'(a_in_ready), 256'd1);

    // Basic frame, consumer always ready.
    a_out_ready = 1'b1;
    a_send_frame(4'd1, 1'b1);
    chk("t1_out_valid", 256'(a_out_valid), 256'd1);
    chk("t1_out_data",  256'(a_out_data),  256'h654321);
    chk("t1_err_len",   256'(a_err_len),   256'd0);
    step();
    chk("t1_out_drop",  256'(a_out_valid), 256'd0);

    // Back-pressure: frame A held, frame B parks in FULL.
    a_out_ready = 1'b0;
    a_send_frame(4'd1, 1'b1);
    chk("t2_a_valid", 256'(a_out_valid), 256'd1);
    chk("t2_a_data",  256'(a_out_data),  256'h654321);
    a_send_frame(4'd7, 1'b1);
    step();
    chk("t2_full_in_ready", 256'(a_in_ready),  256'd0);
    chk("t2_a_held",        256'(a_out_data),  256'h654321);
    chk("t2_a_valid_held",  256'(a_out_valid), 256'd1);
    chk("t2_full_row",      256'(a_cur_row),   256'd0);
    chk("t2_full_col",      256'(a_cur_col),   256'd0);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    chk("t2_b_data",     256'(a_out_data),  256'hCBA987);
    chk("t2_b_valid",    256'(a_out_valid), 256'd1);
    chk("t2_b_in_ready", 256'(a_in_ready),  256'd1);
    a_out_ready = 1'b1;
    step();
    chk("t2_b_drop", 256'(a_out_valid), 256'd0);

    // Early in_last on the third element.
    a_send(4'd1, 1'b0);
    a_send(4'd2, 1'b0);
    a_send(4'd3, 1'b1);
    chk("t3_out_data", 256'(a_out_data), 256'h000321);
    chk("t3_err_len",  256'(a_err_len),  256'd1);
    step();
    chk("t3_err_pulse", 256'(a_err_len), 256'd0);

    // Missing in_last on the sixth element.
    a_send_frame(4'd1, 1'b0);
    chk("t4_out_data", 256'(a_out_data), 256'h654321);
    chk("t4_err_len",  256'(a_err_len),  256'd1);
    step();
    chk("t4_err_pulse", 256'(a_err_len), 256'd0);

    // Reset mid-frame with a frame held on the output.
    a_out_ready = 1'b0;
    a_send_frame(4'd1, 1'b1);
    for (int i = 0; i < 4; i++) a_send(4'd9, 1'b0);
    chk("t5_mid_row", 256'(a_cur_row), 256'd0);
    chk("t5_mid_col", 256'(a_cur_col), 256'd2);
    rst_n = 1'b0;
    step();
    chk("t5_rst_valid",    256'(a_out_valid), 256'd0);
    chk("t5_rst_data",     256'(a_out_data),  256'd0);
    chk("t5_rst_row",      256'(a_cur_row),   256'd0);
    chk("t5_rst_col",      256'(a_cur_col),   256'd0);
    chk("t5_rst_in_ready", 256'(a_in_ready),  256'd0);
    rst_n       = 1'b1;
    a_out_ready = 1'b1;
    step();
    a_send(4'd1, 1'b0);
    a_send(4'd2, 1'b1);
    chk("t5_short_data", 256'(a_out_data), 256'h000021);
    step();
    a_send_frame(4'd1, 1'b1);
    chk("t5_full_data", 256'(a_out_data), 256'h654321);
    a_out_ready = 1'b0;

    // Random valid/ready over 200 frames on the 8x8 instance.
    consumed = 0;
    cyc      = 0;
    k        = 0;
    asm_m    = '0;
    while (consumed < 200 && cyc < 60000) begin
      chk("b_out_valid", 256'(b_out_valid), 256'(q.size() != 0));
      chk("b_in_ready",  256'(b_in_ready),  256'(q.size() < 2));
      b_in_valid  = ($urandom_range(3) != 0);
      b_in_data   = 4'($urandom);
      b_in_last   = (k == 63);
      b_out_ready = 1'($urandom_range(1));
      if (b_out_valid && b_out_ready) begin
        exp_frame = (q.size() != 0) ? q[0] : '1;
        chk("b_frame", b_out_data, exp_frame);
        if (q.size() != 0) void'(q.pop_front());
        consumed++;
      end
      if (b_in_valid && b_in_ready) begin
        chk("b_cur_row", 256'(b_cur_row), 256'(k % 8));
        chk("b_cur_col", 256'(b_cur_col), 256'(k / 8));
        asm_m[k*4 +: 4] = b_in_data;
        if (k == 63) begin
          q.push_back(asm_m);
          asm_m = '0;
          k     = 0;
        end else begin
          k++;
        end
      end
      step();
      cyc++;
    end
    if (consumed < 200) chk("b_timeout", 256'(consumed), 256'd200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
